// File: rtl/uc_multiciclo.sv
// Multicycle RV32I control unit: sequences the shared ALU, unified memory, IR and
// register file for lw/sw/R/I/beq/jal, and traps on any other opcode.
module uc_multiciclo #(
    parameter bit MEM_WAIT = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic [2:0] f3,
    input  logic       f7,
    input  logic       zero,
    input  logic       memReady,
    output logic       pcWrite,
    output logic       adrSrc,
    output logic       memWrite,
    output logic       irWrite,
    output logic [1:0] resSrc,
    output logic [1:0] aluSrcA,
    output logic [1:0] aluSrcB,
    output logic [2:0] ALUControl,
    output logic [1:0] inmSrc,
    output logic       regWrite,
    output logic       instrDone,
    output logic       illegalInstr,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_TRAP     = 4'd11
    } state_t;

    typedef enum logic [1:0] {
        OP_ADD   = 2'd0,
        OP_SUB   = 2'd1,
        OP_FUNCT = 2'd2
    } alu_op_t;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;
    localparam logic [6:0] OPC_RTYPE = 7'b0110011;
    localparam logic [6:0] OPC_ITYPE = 7'b0010011;
    localparam logic [6:0] OPC_BEQ   = 7'b1100011;
    localparam logic [6:0] OPC_JAL   = 7'b1101111;

    state_t  cur, nxt;
    alu_op_t alu_op;
    logic    illegal_q;
    logic    ready;
    logic    pc_w, mem_w, ir_w, reg_w;

    // Only R-type (op[5]=1) can select sub through funct; I-type addi ignores f7.
    function automatic logic [2:0] alu_decode(input alu_op_t aop, input logic op5,
                                              input logic [2:0] fn3, input logic fn7);
        logic [2:0] ctl;
        ctl = 3'b000;
        case (aop)
            OP_SUB:   ctl = 3'b001;
            OP_FUNCT: begin
                case (fn3)
                    3'b000:  ctl = (op5 & fn7) ? 3'b001 : 3'b000;
                    3'b010:  ctl = 3'b101;
                    3'b110:  ctl = 3'b011;
                    3'b111:  ctl = 3'b010;
                    default: ctl = 3'b000;
                endcase
            end
            default:  ctl = 3'b000;
        endcase
        return ctl;
    endfunction

    function automatic logic [1:0] imm_decode(input logic [6:0] opc);
        logic [1:0] sel;
        case (opc)
            OPC_STORE: sel = 2'b01;
            OPC_BEQ:   sel = 2'b10;
            OPC_JAL:   sel = 2'b11;
            default:   sel = 2'b00;
        endcase
        return sel;
    endfunction

    assign ready = MEM_WAIT ? memReady : 1'b1;

    always_comb begin
        nxt       = S_FETCH;
        alu_op    = OP_ADD;
        pc_w      = 1'b0;
        mem_w     = 1'b0;
        ir_w      = 1'b0;
        reg_w     = 1'b0;
        adrSrc    = 1'b0;
        resSrc    = 2'b00;
        aluSrcA   = 2'b00;
        aluSrcB   = 2'b00;
        instrDone = 1'b0;
        case (cur)
            S_FETCH: begin
                aluSrcB = 2'b10;
                resSrc  = 2'b10;
                // PC and IR load together, only on the completing cycle of the fetch.
                pc_w    = ready;
                ir_w    = ready;
                nxt     = ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                aluSrcA = 2'b01;
                aluSrcB = 2'b01;
                case (op)
                    OPC_LOAD, OPC_STORE: nxt = S_MEMADR;
                    OPC_RTYPE:           nxt = S_EXECR;
                    OPC_ITYPE:           nxt = S_EXECI;
                    OPC_BEQ:             nxt = S_BEQ;
                    OPC_JAL:             nxt = S_JAL;
                    default:             nxt = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                aluSrcA = 2'b10;
                aluSrcB = 2'b01;
                nxt     = op[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                adrSrc = 1'b1;
                nxt    = ready ? S_MEMWB : S_MEMREAD;
            end
            S_MEMWB: begin
                resSrc    = 2'b01;
                reg_w     = 1'b1;
                instrDone = 1'b1;
            end
            S_MEMWRITE: begin
                adrSrc    = 1'b1;
                mem_w     = 1'b1;
                instrDone = ready;
                nxt       = ready ? S_FETCH : S_MEMWRITE;
            end
            S_EXECR: begin
                aluSrcA = 2'b10;
                alu_op  = OP_FUNCT;
                nxt     = S_ALUWB;
            end
            S_EXECI: begin
                aluSrcA = 2'b10;
                aluSrcB = 2'b01;
                alu_op  = OP_FUNCT;
                nxt     = S_ALUWB;
            end
            S_ALUWB: begin
                reg_w     = 1'b1;
                instrDone = 1'b1;
            end
            S_BEQ: begin
                aluSrcA   = 2'b10;
                alu_op    = OP_SUB;
                pc_w      = zero;
                instrDone = 1'b1;
            end
            S_JAL: begin
                // aluOut still holds the target computed in DECODE; ALU forms oldPC+4 for rd.
                aluSrcA = 2'b01;
                aluSrcB = 2'b10;
                pc_w    = 1'b1;
                nxt     = S_ALUWB;
            end
            S_TRAP:  nxt = S_TRAP;
            default: nxt = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cur       <= S_FETCH;
            illegal_q <= 1'b0;
        end else begin
            cur <= nxt;
            if (nxt == S_TRAP)
                illegal_q <= 1'b1;
        end
    end

    assign pcWrite      = pc_w  & rst_n;
    assign memWrite     = mem_w & rst_n;
    assign irWrite      = ir_w  & rst_n;
    assign regWrite     = reg_w & rst_n;
    assign ALUControl   = alu_decode(alu_op, op[5], f3, f7);
    assign inmSrc       = imm_decode(op);
    assign illegalInstr = illegal_q;
    assign state        = cur;

endmodule
